ld_agu_queue: RTL
=================

Name: ld_agu_queue

Overview:
- Parametrised load address-generation unit with an in-order load buffer.
- Accepts load micro-ops from dispatch and holds them until their base operand is available, either from the register file or captured from ROB forwarding channels.
- Computes base + extended offset and presents one address per cycle to the memory stage over a valid/ready handshake.
- Sits between the load dispatch buffer and the data-cache / load-store-queue stage.

Parameters:
- XLEN, 32, address/data width.
- IMM_W, 16, offset immediate width.
- DEPTH, 4, load buffer entries (power of two, >=2).
- TAG_W, 5, ROB tag width.
- NUM_FWD, 2, number of ROB forwarding channels.
- INO_W, 32, instruction-number width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous squash of all held loads.
- in_valid  in  1  dispatch offers a load.
- in_ready  out  1  buffer can accept.
- in_imm  in  IMM_W  offset immediate.
- in_sext  in  1  1=sign-extend imm, 0=zero-extend.
- in_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
- in_base_rdy  in  1  in_base_val is valid.
- in_base_val  in  XLEN  base from register file.
- in_base_tag  in  TAG_W  ROB tag producing base when not ready.
- in_ino  in  INO_W  load instruction number.
- fwd_valid  in  NUM_FWD  per-channel ROB result valid.
- fwd_tag  in  NUM_FWD*TAG_W  channel i at [i*TAG_W +: TAG_W].
- fwd_data  in  NUM_FWD*XLEN  channel i at [i*XLEN +: XLEN].
- out_valid  out  1  address valid.
- out_ready  in  1  memory stage accepts.
- out_addr  out  XLEN  effective address.
- out_ino  out  INO_W  instruction number of out_addr.
- out_size  out  2  access size passed through.
- out_misalign  out  1  address not aligned to out_size.

Behaviour:
- Reset (rst_n=0 at clk edge): queue empty, all entry valid bits 0, out_valid=0, out_addr/out_ino/out_size/out_misalign=0. in_ready=1 from the first cycle after reset.
- Enqueue when in_valid && in_ready. The entry stores imm, sext, size, ino, base_rdy, base_val, tag.
- in_ready = (count < DEPTH). No same-cycle enqueue-on-full bypass.
- Wake-up: each cycle, every valid entry with base_rdy=0 compares its tag against all fwd channels with fwd_valid=1. On a match it latches fwd_data and sets base_rdy. If several channels match, the lowest index wins.
- Issue is strictly in order, head only. The head issues when its base_rdy=1 and the output register is empty or being drained (out_ready=1).
- A younger ready entry never bypasses a non-ready head.
- Issue action: out_addr = base + ext(imm), modulo 2^XLEN (carry discarded), where ext sign- or zero-extends IMM_W to XLEN. out_ino and out_size are copied; out_valid=1.
- Latency: a load enqueued with base ready at edge k is visible at out_valid after edge k+1, provided the queue and output register are empty.
- Throughput: 1 address per cycle.
- Output register holds all outputs stable while out_valid && !out_ready.
- Head/tail pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits. Simultaneous enqueue and issue keeps count unchanged.
- flush: at the clock edge, all entries are invalidated, count=0, out_valid=0. Any enqueue, wake-up or issue in that cycle is discarded. flush has lower priority than reset.
- Forwarding that matches an entry in the same cycle it issues is ignored, because the entry is already ready.

Optional Feature:
- Macro LD_AGU_MISALIGN_CHK_EN.
- Defined: out_misalign = (size==1 && addr[0]) || (size>=2 && addr[1:0]!=0), registered with out_addr.
- Undefined: out_misalign tied to 0 and no checker logic is present.
- Fwd-on-enqueue capture is always present: an incoming entry with in_base_rdy=0 whose tag matches a forwarding channel in the enqueue cycle is stored as ready.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> out_valid=0, out_addr=0, in_ready=1.
- Sign/zero extension: enqueue base_rdy=1, base=0x00001000, imm=0xFFFC, out_ready=1.
  - sext=1 -> out_addr=0x00000FFC one cycle later.
  - sext=0 -> out_addr=0x00010FFC.
- Forward wake-up with head-of-line block:
  - Stimulus: load A (base_rdy=0, tag=3, imm=4) then load B (ready, base=0x100). Two cycles later drive fwd_valid[1]=1, fwd_tag=3, data=0x2000.
  - Response: A issues with addr 0x2004, then B issues with 0x100 the following cycle; B never issues before A.
- Back-pressure/full (DEPTH=4): ready loads offered every cycle with out_ready=0 -> five loads accepted (4 queue + output register), then in_ready=0. out_addr stays stable. Raising out_ready drains one per cycle in order.
- Flush mid-operation: three loads held, two not ready. Assert flush for one cycle -> out_valid=0 and in_ready=1 next cycle; a subsequent fwd with a matching tag produces no output.
- With LD_AGU_MISALIGN_CHK_EN: base=0x1000, imm=2, size=2 -> out_misalign=1; size=1 -> 0. Without the macro -> always 0.

Source files
------------

// File: rtl/ld_agu_queue.sv
// Load address-generation unit with an in-order load buffer and ROB-forward wake-up.
// Optional misalignment checker enabled by defining LD_AGU_MISALIGN_CHK_EN.
module ld_agu_queue #(
  parameter int XLEN    = 32,
  parameter int IMM_W   = 16,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5,
  parameter int NUM_FWD = 2,
  parameter int INO_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IMM_W-1:0]           in_imm,
  input  logic                       in_sext,
  input  logic [1:0]                 in_size,
  input  logic                       in_base_rdy,
  input  logic [XLEN-1:0]            in_base_val,
  input  logic [TAG_W-1:0]           in_base_tag,
  input  logic [INO_W-1:0]           in_ino,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*TAG_W-1:0]   fwd_tag,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_addr,
  output logic [INO_W-1:0]           out_ino,
  output logic [1:0]                 out_size,
  output logic                       out_misalign
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_rdy;
  logic [DEPTH-1:0] e_sext;
  logic [IMM_W-1:0] e_imm  [DEPTH];
  logic [1:0]       e_size [DEPTH];
  logic [INO_W-1:0] e_ino  [DEPTH];
  logic [XLEN-1:0]  e_base [DEPTH];
  logic [TAG_W-1:0] e_tag  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [DEPTH-1:0] wake_hit;
  logic [XLEN-1:0]  wake_data [DEPTH];
  logic             enq_hit;
  logic [XLEN-1:0]  enq_data;

  logic             do_enq;
  logic             do_issue;
  logic [XLEN-1:0]  issue_addr;

  // Returns {hit, data}; scanning from the top down lets the lowest channel win.
  function automatic logic [XLEN:0] fwd_lookup(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_FWD-1:0]       fv,
    input logic [NUM_FWD*TAG_W-1:0] ft,
    input logic [NUM_FWD*XLEN-1:0]  fd
  );
    logic [XLEN:0] r;
    r = '0;
    for (int c = NUM_FWD-1; c >= 0; c--) begin
      if (fv[c] && (ft[c*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, fd[c*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] imm_ext(input logic [IMM_W-1:0] imm, input logic sext);
    logic fill;
    fill = sext & imm[IMM_W-1];
    return {{(XLEN-IMM_W){fill}}, imm};
  endfunction

  always_comb begin
    wake_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake_data[i] = '0;
      {wake_hit[i], wake_data[i]} = fwd_lookup(e_tag[i], fwd_valid, fwd_tag, fwd_data);
    end
  end

  assign {enq_hit, enq_data} = fwd_lookup(in_base_tag, fwd_valid, fwd_tag, fwd_data);

  assign in_ready   = (count < CNT_FULL);
  assign do_enq     = in_valid && in_ready;
  assign do_issue   = (count != '0) && e_rdy[head] && (!out_valid || out_ready);
  assign issue_addr = e_base[head] + imm_ext(e_imm[head], e_sext[head]);

`ifdef LD_AGU_MISALIGN_CHK_EN
  logic misalign_q;

  function automatic logic is_misaligned(input logic [XLEN-1:0] a, input logic [1:0] s);
    return ((s == 2'd1) && a[0]) || (s[1] && (a[1:0] != 2'b00));
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (!flush && do_issue) begin
      misalign_q <= is_misaligned(issue_addr, e_size[head]);
    end
  end

  assign out_misalign = misalign_q;
`else
  assign out_misalign = 1'b0;
`endif

  // Buffer state, wake-up and the output register share one block so flush can discard all of them together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_valid   <= '0;
      e_rdy     <= '0;
      e_sext    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_imm[i]  <= '0;
        e_size[i] <= '0;
        e_ino[i]  <= '0;
        e_base[i] <= '0;
        e_tag[i]  <= '0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_ino   <= '0;
      out_size  <= '0;
    end else if (flush) begin
      e_valid   <= '0;
      e_rdy     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && !e_rdy[i] && wake_hit[i]) begin
          e_rdy[i]  <= 1'b1;
          e_base[i] <= wake_data[i];
        end
      end

      if (do_issue) begin
        e_valid[head] <= 1'b0;
        e_rdy[head]   <= 1'b0;
        head          <= head + PTR_ONE;
        out_valid     <= 1'b1;
        out_addr      <= issue_addr;
        out_ino       <= e_ino[head];
        out_size      <= e_size[head];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Tail slot is always free here, so it never collides with wake-up or the head clear.
      if (do_enq) begin
        e_valid[tail] <= 1'b1;
        e_rdy[tail]   <= in_base_rdy | enq_hit;
        e_base[tail]  <= in_base_rdy ? in_base_val : enq_data;
        e_tag[tail]   <= in_base_tag;
        e_imm[tail]   <= in_imm;
        e_sext[tail]  <= in_sext;
        e_size[tail]  <= in_size;
        e_ino[tail]   <= in_ino;
        tail          <= tail + PTR_ONE;
      end

      case ({do_enq, do_issue})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
